// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command issue path: select codes, issue FSM states, trap pattern.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_MUL = 3'b010;
    localparam logic [2:0] ALU_DIV = 3'b011;
    localparam logic [2:0] ALU_GCD = 3'b100;
    localparam logic [2:0] ALU_POW = 3'b101;

    localparam logic [31:0] DIV0_PATTERN = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2
    } issue_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: W-bit entries, DEPTH deep, head presented combinationally on pop_dat.
// Latency: a pushed entry is visible at the head the cycle after the push edge.
// Backpressure: push ignored while full, pop ignored while empty; push+pop when full is not a push.
module alu_cmd_fifo #(
    parameter int W     = 67,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    output logic [W-1:0]               pop_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_en, pop_en;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign pop_dat = mem[rptr_q];
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_en) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop_en) begin
            rptr_d = rptr_q + AW'(1);
        end
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the pointers decide which entries are live.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/alu_cmd_issue.sv
// Issue stage for the combinational ALU: queues commands, drives one at a time, registers the result.
// Latency: response valid SETTLE+1 edges after accept from idle; divide-by-zero trap after 1 edge.
// Backpressure: cmd_ready drops when the FIFO is full; a response is held stable until rsp_ready.
module alu_cmd_issue
    import alu_pkg::*;
#(
    parameter int DW     = 32,
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [DW-1:0] cmd_a,
    input  logic [DW-1:0] cmd_b,
    input  logic [2:0]    cmd_sel,
    output logic [DW-1:0] alu_inp1,
    output logic [DW-1:0] alu_inp2,
    output logic [2:0]    alu_select,
    input  logic [DW-1:0] alu_res,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic [2:0]    rsp_sel,
    output logic          rsp_err
);

    localparam int CW = DW + DW + 3;
    localparam int AW = $clog2(DEPTH);
    localparam int WW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_pop_dat;
    logic [AW:0]   fifo_count;
    logic [DW-1:0] head_a, head_b;
    logic [2:0]    head_sel;
    logic          issue;

    issue_state_e  state_q, state_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic [DW-1:0] alu_inp1_q, alu_inp1_d;
    logic [DW-1:0] alu_inp2_q, alu_inp2_d;
    logic [2:0]    alu_select_q, alu_select_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic [2:0]    rsp_sel_q, rsp_sel_d;
    logic          rsp_err_q, rsp_err_d;

    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready;
    assign {head_a, head_b, head_sel} = fifo_pop_dat;

    alu_cmd_fifo #(
        .W     (CW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_dat ({cmd_a, cmd_b, cmd_sel}),
        .pop      (fifo_pop),
        .pop_dat  (fifo_pop_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        alu_inp1_d   = alu_inp1_q;
        alu_inp2_d   = alu_inp2_q;
        alu_select_d = alu_select_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_sel_d    = rsp_sel_q;
        rsp_err_d    = rsp_err_q;
        fifo_pop     = 1'b0;
        issue        = 1'b0;

        case (state_q)
            IDLE: begin
                issue = !fifo_empty;
            end
            DRIVE: begin
                if (wcnt_q == '0) begin
                    rsp_data_d  = alu_res;
                    rsp_sel_d   = alu_select_q;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = HOLD;
                end else begin
                    wcnt_d = wcnt_q - WW'(1);
                end
            end
            HOLD: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                    issue       = !fifo_empty;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Shared by IDLE and the back-to-back path out of HOLD.
        if (issue) begin
            fifo_pop = 1'b1;
            if (head_sel == ALU_DIV && head_b == '0) begin
                rsp_data_d  = {DW{1'b1}};
                rsp_sel_d   = ALU_DIV;
                rsp_err_d   = 1'b1;
                rsp_valid_d = 1'b1;
                state_d     = HOLD;
            end else begin
                alu_inp1_d   = head_a;
                alu_inp2_d   = head_b;
                alu_select_d = head_sel;
                wcnt_d       = WW'(SETTLE - 1);
                state_d      = DRIVE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wcnt_q       <= '0;
            alu_inp1_q   <= '0;
            alu_inp2_q   <= '0;
            alu_select_q <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_sel_q    <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            alu_inp1_q   <= alu_inp1_d;
            alu_inp2_q   <= alu_inp2_d;
            alu_select_q <= alu_select_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_sel_q    <= rsp_sel_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign alu_inp1   = alu_inp1_q;
    assign alu_inp2   = alu_inp2_q;
    assign alu_select = alu_select_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_sel    = rsp_sel_q;
    assign rsp_err    = rsp_err_q;

    count_in_range: assert property (@(posedge clk) disable iff (rst)
        fifo_count <= (AW+1)'(DEPTH));

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Bench for alu_cmd_issue with a behavioural ALU; responses are scoreboarded in command order.
module tb_alu_cmd_issue;
    import alu_pkg::*;

    localparam int DW     = 32;
    localparam int DEPTH  = 4;
    localparam int SETTLE = 1;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  sel;
        logic        err;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [DW-1:0] cmd_a, cmd_b;
    logic [2:0]    cmd_sel;
    logic [DW-1:0] alu_inp1, alu_inp2, alu_res;
    logic [2:0]    alu_select;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [2:0]    rsp_sel;
    logic          rsp_err;

    logic ready_rand_en = 1'b0;
    logic ready_force   = 1'b1;
    logic ready_rnd     = 1'b1;

    rsp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    assign rsp_ready = ready_rand_en ? ready_rnd : ready_force;

    alu_cmd_issue #(
        .DW     (DW),
        .DEPTH  (DEPTH),
        .SETTLE (SETTLE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_sel    (cmd_sel),
        .alu_inp1   (alu_inp1),
        .alu_inp2   (alu_inp2),
        .alu_select (alu_select),
        .alu_res    (alu_res),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_sel    (rsp_sel),
        .rsp_err    (rsp_err)
    );

    function automatic logic [31:0] alu_fn(input logic [2:0] sel, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [31:0] x, y, t, r, base, e;
        case (sel)
            3'b001:  return (a > b) ? (a - b) : (b - a);
            3'b010:  return a * b;
            3'b011:  return (b == 0) ? 32'd0 : a / b;
            3'b100: begin
                x = a;
                y = b;
                for (int i = 0; i < 64; i++) begin
                    if (y != 0) begin
                        t = x % y;
                        x = y;
                        y = t;
                    end
                end
                return x;
            end
            3'b101: begin
                r    = 32'd1;
                base = a;
                e    = b;
                for (int i = 0; i < 32; i++) begin
                    if (e[0]) r = r * base;
                    base = base * base;
                    e    = e >> 1;
                end
                return r;
            end
            default: return a + b;
        endcase
    endfunction

    always_comb alu_res = alu_fn(alu_select, alu_inp1, alu_inp2);

    function automatic rsp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] sel);
        rsp_t r;
        if (sel == ALU_DIV && b == 0) begin
            r.data = DIV0_PATTERN;
            r.err  = 1'b1;
        end else begin
            r.data = alu_fn(sel, a, b);
            r.err  = 1'b0;
        end
        r.sel = sel;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            ready_rnd = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops on every handshake and checks stability of stalled responses.
    initial begin
        logic [36:0] held;
        logic        stall;
        rsp_t        e;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    check("hold_stable", 64'({rsp_valid, rsp_data, rsp_sel, rsp_err}), 64'(held));
                end
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_rsp: got data=%h sel=%b err=%b, expected none",
                                 rsp_data, rsp_sel, rsp_err);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp", 64'({rsp_data, rsp_sel, rsp_err}), 64'(e));
                    end
                end
                stall = rsp_valid && !rsp_ready;
                held  = {1'b1, rsp_data, rsp_sel, rsp_err};
            end
        end
    end

    task automatic push_cmd(input logic [31:0] a, input logic [31:0] b, input logic [2:0] sel);
        int waited = 0;
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_sel   = sel;
        forever begin
            @(negedge clk);
            if (cmd_ready || waited >= 200) break;
            waited++;
        end
        if (!cmd_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: cmd_ready=0 after %0d cycles, expected 1", waited);
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back(model(a, b, sel));
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((exp_q.size() != 0 || rsp_valid) && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  sel_before;
        logic [31:0] inp1_before, inp2_before;
        logic [31:0] ra, rb;
        logic [2:0]  rs;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_sel   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_err", 64'(rsp_err), 64'(0));
        check("rst_rsp_data", 64'(rsp_data), 64'(0));
        check("rst_rsp_sel", 64'(rsp_sel), 64'(0));
        check("rst_alu_regs", 64'({alu_inp1, alu_inp2, alu_select}), 64'(0));
        check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        @(posedge clk);
        #1;

        // Add from idle: valid rises after edge SETTLE+1.
        ready_force = 1'b1;
        push_cmd(32'd8, 32'd4, ALU_ADD);
        @(negedge clk);
        check("add_lat_e0", 64'(rsp_valid), 64'(0));
        @(negedge clk);
        check("add_lat_e1", 64'(rsp_valid), 64'(0));
        @(negedge clk);
        check("add_lat_e2", 64'(rsp_valid), 64'(1));
        wait_drain();

        // Fill: one response held plus DEPTH queued, then the next push must wait.
        ready_force = 1'b0;
        push_cmd(32'd4, 32'd8, ALU_SUB);
        push_cmd(32'd8, 32'd4, ALU_MUL);
        push_cmd(32'd8, 32'd4, ALU_DIV);
        push_cmd(32'd8, 32'd4, ALU_GCD);
        push_cmd(32'd7, 32'd9, ALU_ADD);
        cmd_valid = 1'b1;
        cmd_a     = 32'd9;
        cmd_b     = 32'd3;
        cmd_sel   = ALU_MUL;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_cmd_ready", 64'(cmd_ready), 64'(0));
        end
        @(posedge clk);
        #1;
        ready_force = 1'b1;
        push_cmd(32'd9, 32'd3, ALU_MUL);
        wait_drain();

        // Divide by zero: trapped after one edge, ALU inputs untouched.
        sel_before  = alu_select;
        inp1_before = alu_inp1;
        inp2_before = alu_inp2;
        push_cmd(32'd8, 32'd0, ALU_DIV);
        @(negedge clk);
        check("div0_lat_e0", 64'(rsp_valid), 64'(0));
        @(negedge clk);
        check("div0_lat_e1", 64'(rsp_valid), 64'(1));
        check("div0_alu_regs", 64'({alu_inp1, alu_inp2, alu_select}),
              64'({inp1_before, inp2_before, sel_before}));
        wait_drain();

        // Power result held under backpressure.
        ready_force = 1'b0;
        push_cmd(32'd8, 32'd4, ALU_POW);
        repeat (7) @(negedge clk);
        check("pow_waiting", 64'(rsp_valid), 64'(1));
        @(posedge clk);
        #1;
        ready_force = 1'b1;
        wait_drain();

        // Reset while a command is in DRIVE with two more queued.
        ready_force = 1'b0;
        push_cmd(32'd1, 32'd2, ALU_ADD);
        push_cmd(32'd3, 32'd4, ALU_ADD);
        push_cmd(32'd5, 32'd6, ALU_ADD);
        push_cmd(32'd7, 32'd8, ALU_ADD);
        @(negedge clk);
        check("pre_rst_valid", 64'(rsp_valid), 64'(1));
        @(posedge clk);
        #1;
        ready_force = 1'b1;
        @(posedge clk);
        #1;
        ready_force = 1'b0;
        rst         = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("midrst_cmd_ready", 64'(cmd_ready), 64'(1));
        @(posedge clk);
        #1;
        rst         = 1'b0;
        ready_force = 1'b1;
        repeat (10) @(negedge clk);
        check("no_stale_rsp", 64'(rsp_valid), 64'(0));
        @(posedge clk);
        #1;

        // Select 111 passes through and behaves as add.
        push_cmd(32'd3, 32'd5, 3'b111);
        wait_drain();

        // Randomized traffic with random consumer backpressure.
        ready_rand_en = 1'b1;
        for (int n = 0; n < 200; n++) begin
            int gap;
            gap = $urandom_range(0, 2);
            if (gap != 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
            rs = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            if (rs == ALU_DIV && $urandom_range(0, 2) == 0) rb = 32'd0;
            if (rs == ALU_DIV && $urandom_range(0, 1) == 0) rb = rb & 32'hFF;
            if (rs == ALU_POW && $urandom_range(0, 1) == 0) rb = 32'($urandom_range(0, 40));
            push_cmd(ra, rb, rs);
        end
        ready_rand_en = 1'b0;
        ready_force   = 1'b1;
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
